// File: rtl/regfile_pkg.sv
// regfile_pkg: op codes, FSM states and op width shared by the register file, its bus and the bench
package regfile_pkg;
  localparam int OPW = 3;
  typedef enum logic [OPW-1:0] {
    OP_NOP    = 3'd0,
    OP_WRITE  = 3'd1,
    OP_SWAP   = 3'd2,
    OP_INC_IX = 3'd3,
    OP_DEC_IX = 3'd4,
    OP_CLEAR  = 3'd5
  } op_t;
  typedef enum logic {S_IDLE, S_SWEEP} state_t;
endpackage

// File: rtl/regfile_xchg_if.sv
// regfile_xchg_if: op handshake and read/write bus; master drives op/op_valid/wa/ra/rb/rc0/wdata, slave drives op_ready/busy/outa/outb/outc/oix
interface regfile_xchg_if import regfile_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int AW = $clog2(NREGS);
  logic [OPW-1:0] op;
  logic op_valid;
  logic op_ready;
  logic busy;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic rc0;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] outa;
  logic [WIDTH-1:0] outb;
  logic [WIDTH-1:0] outc;
  logic [WIDTH-1:0] oix;
  modport master(output op, op_valid, wa, ra, rb, rc0, wdata, input op_ready, busy, outa, outb, outc, oix);
  modport slave(input op, op_valid, wa, ra, rb, rc0, wdata, output op_ready, busy, outa, outb, outc, oix);
endinterface

// File: rtl/reg_n_bit.sv
// reg_n_bit: WIDTH-bit register; ports clk, i_clear_n (async active-low clear), i_load, i_d in, o_q out
module reg_n_bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             i_clear_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;
  always_ff @(posedge clk or negedge i_clear_n)
    if (!i_clear_n) r_q <= '0;
    else if (i_load) r_q <= i_d;
  assign o_q = r_q;
endmodule

// File: rtl/regfile_xchg.sv
// regfile_xchg: NREGS x WIDTH register file (top reg is IX) with write, swap, IX inc/dec and a CLEAR sweep; ports clk, rst_n, bus (slave modport)
module regfile_xchg import regfile_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input logic           clk,
  input logic           rst_n,
  regfile_xchg_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
  state_t r_state, w_state_nxt;
  logic [AW-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] w_q [NREGS];
  logic w_acc, w_sweep;
  assign w_sweep = r_state == S_SWEEP;
  assign w_acc = bus.op_valid && !w_sweep;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
    end
  always_comb begin
    w_state_nxt = w_sweep ? (r_cnt == LAST ? S_IDLE : S_SWEEP) : (w_acc && bus.op == OP_CLEAR ? S_SWEEP : S_IDLE);
    w_cnt_nxt = w_sweep ? r_cnt + AW'(1) : '0;
  end
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    localparam logic [AW-1:0] IDX = AW'(i);
    localparam bit IS_IX = i == NREGS - 1;
    logic w_clr, w_wr, w_sa, w_sb, w_inc, w_dec;
    logic [WIDTH-1:0] w_d;
    assign w_clr = w_sweep && r_cnt == IDX;
    assign w_wr = w_acc && bus.op == OP_WRITE && bus.wa == IDX;
    assign w_sa = w_acc && bus.op == OP_SWAP && bus.ra == IDX;
    assign w_sb = w_acc && bus.op == OP_SWAP && bus.rb == IDX;
    assign w_inc = IS_IX && w_acc && bus.op == OP_INC_IX;
    assign w_dec = IS_IX && w_acc && bus.op == OP_DEC_IX;
    // sweep and accepted ops never coincide; RA==RB swap reloads the same value
    assign w_d = w_clr ? '0 : w_wr ? bus.wdata : w_sa ? w_q[bus.rb] : w_sb ? w_q[bus.ra] :
                 w_inc ? w_q[i] + WIDTH'(1) : w_q[i] - WIDTH'(1);
    reg_n_bit #(.WIDTH(WIDTH)) u_reg (
      .clk      (clk),
      .i_clear_n(rst_n),
      .i_load   (w_clr | w_wr | w_sa | w_sb | w_inc | w_dec),
      .i_d      (w_d),
      .o_q      (w_q[i])
    );
  end
  assign bus.op_ready = !w_sweep;
  assign bus.busy = w_sweep;
  assign bus.outa = w_q[bus.ra];
  assign bus.outb = w_q[bus.rb];
  assign bus.outc = {WIDTH{bus.rc0}};
  assign bus.oix = w_q[NREGS-1];
endmodule

// File: tb/tb_regfile_xchg.sv
// tb_regfile_xchg: scoreboard bench for regfile_xchg at 4x8 (dut0) and 8x16 (dut1)
module tb_regfile_xchg;
  import regfile_pkg::*;
  localparam int K_A = 0, K_B = 1, K_IX = 2, K_BUSY = 3, K_RDY = 4, K_C = 5;
  typedef struct {string tag; int s; int k; logic [15:0] exp;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  logic [15:0] m [2][8];
  regfile_xchg_if #(.WIDTH(8), .NREGS(4)) b0 ();
  regfile_xchg_if #(.WIDTH(16), .NREGS(8)) b1 ();
  regfile_xchg #(.WIDTH(8), .NREGS(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  regfile_xchg #(.WIDTH(16), .NREGS(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] obs(input int s, input int k);
    if (s == 0)
      return k == K_A ? 16'(b0.outa) : k == K_B ? 16'(b0.outb) : k == K_IX ? 16'(b0.oix) :
             k == K_BUSY ? 16'(b0.busy) : k == K_RDY ? 16'(b0.op_ready) : 16'(b0.outc);
    return k == K_A ? b1.outa : k == K_B ? b1.outb : k == K_IX ? b1.oix :
           k == K_BUSY ? 16'(b1.busy) : k == K_RDY ? 16'(b1.op_ready) : b1.outc;
  endfunction
  task automatic push(input string tag, input int s, input int k, input logic [15:0] exp);
    exp_t e;
    e.tag = tag; e.s = s; e.k = k; e.exp = exp;
    sb.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.s, e.k), e.exp);
    end
  endtask
  task automatic drv(input int s, input logic [2:0] c, input logic v, input int wa, input int ra, input int rb, input logic [15:0] d);
    if (s == 0) begin
      b0.op = c; b0.op_valid = v; b0.wa = 2'(wa); b0.ra = 2'(ra); b0.rb = 2'(rb); b0.wdata = d[7:0];
    end else begin
      b1.op = c; b1.op_valid = v; b1.wa = 3'(wa); b1.ra = 3'(ra); b1.rb = 3'(rb); b1.wdata = d;
    end
  endtask
  task automatic apply(input int s, input logic [2:0] c, input int wa, input int ra, input int rb, input logic [15:0] d);
    int ix = s != 0 ? 7 : 3;
    logic [15:0] mk = s != 0 ? 16'hFFFF : 16'h00FF;
    logic [15:0] t;
    if (c == OP_WRITE) m[s][wa] = d & mk;
    else if (c == OP_SWAP) begin
      t = m[s][ra]; m[s][ra] = m[s][rb]; m[s][rb] = t;
    end else if (c == OP_INC_IX) m[s][ix] = 16'(m[s][ix] + 16'd1) & mk;
    else if (c == OP_DEC_IX) m[s][ix] = 16'(m[s][ix] - 16'd1) & mk;
  endtask
  task automatic issue(input int s, input logic [2:0] c, input int wa, input int ra, input int rb, input logic [15:0] d, input string tag);
    int ix = s != 0 ? 7 : 3;
    drv(s, c, 1'b1, wa, ra, rb, d);
    apply(s, c, wa, ra, rb, d);
    push({tag, "_outa"}, s, K_A, m[s][ra]);
    push({tag, "_outb"}, s, K_B, m[s][rb]);
    push({tag, "_oix"}, s, K_IX, m[s][ix]);
    push({tag, "_rdy"}, s, K_RDY, 16'h1);
    @(posedge clk); #1;
    drv(s, OP_NOP, 1'b0, wa, ra, rb, d);
    drain();
  endtask
  task automatic sweep(input int s, input logic hw, input int wa, input logic [15:0] d, input string tag);
    int n = s != 0 ? 8 : 4;
    logic [15:0] old [8];
    for (int i = 0; i < 8; i++) old[i] = m[s][i];
    drv(s, OP_CLEAR, 1'b1, 0, 0, 0, 16'h0);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      drv(s, hw ? OP_WRITE : OP_NOP, hw, wa, k > 0 ? k - 1 : 0, k, d);
      #1;
      push({tag, "_busy"}, s, K_BUSY, 16'h1);
      push({tag, "_nrdy"}, s, K_RDY, 16'h0);
      push({tag, "_keep"}, s, K_B, old[k]);
      if (k > 0) push({tag, "_zeroed"}, s, K_A, 16'h0);
      drain();
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) m[s][i] = 16'h0;
    drv(s, hw ? OP_WRITE : OP_NOP, hw, wa, wa, n - 1, d);
    #1;
    push({tag, "_done"}, s, K_BUSY, 16'h0);
    push({tag, "_rdy"}, s, K_RDY, 16'h1);
    push({tag, "_held"}, s, K_A, 16'h0);
    push({tag, "_ix0"}, s, K_IX, 16'h0);
    drain();
    @(posedge clk); #1;
    if (hw) apply(s, OP_WRITE, wa, 0, 0, d);
    drv(s, OP_NOP, 1'b0, wa, wa, n - 1, d);
    push({tag, "_after"}, s, K_A, m[s][wa]);
    drain();
  endtask
  initial begin
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) m[s][i] = 16'h0;
    drv(0, OP_NOP, 1'b0, 0, 0, 0, 16'h0);
    drv(1, OP_NOP, 1'b0, 0, 0, 0, 16'h0);
    b0.rc0 = 1'b1;
    b1.rc0 = 1'b1;
    #2;
    push("inrst_c1", 0, K_C, 16'h00FF);
    push("inrst_a", 0, K_A, 16'h0);
    drain();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      push("rst_outa", s, K_A, 16'h0);
      push("rst_outb", s, K_B, 16'h0);
      push("rst_oix", s, K_IX, 16'h0);
      push("rst_busy", s, K_BUSY, 16'h0);
      push("rst_rdy", s, K_RDY, 16'h1);
      push("rst_c1", s, K_C, s != 0 ? 16'hFFFF : 16'h00FF);
    end
    drain();
    b0.rc0 = 1'b0;
    b1.rc0 = 1'b0;
    #1;
    push("rst_c0", 0, K_C, 16'h0);
    push("rst_c0", 1, K_C, 16'h0);
    drain();
    issue(0, OP_WRITE, 1, 1, 1, 16'h3C, "wr1");
    issue(0, OP_WRITE, 2, 2, 2, 16'hA5, "wr2");
    issue(0, OP_SWAP, 0, 1, 2, 16'h0, "swap12");
    issue(0, OP_SWAP, 0, 2, 2, 16'h0, "swap22");
    issue(0, OP_WRITE, 3, 3, 3, 16'hFF, "wrix");
    issue(0, OP_INC_IX, 0, 0, 3, 16'h0, "inc_wrap");
    issue(0, OP_DEC_IX, 0, 0, 3, 16'h0, "dec_wrap");
    issue(0, OP_DEC_IX, 0, 0, 3, 16'h0, "dec2");
    issue(0, 3'd6, 1, 1, 2, 16'h55, "rsv6");
    issue(0, OP_SWAP, 0, 0, 3, 16'h0, "swap_ix");
    for (int i = 0; i < 4; i++) issue(0, OP_WRITE, i, i, 0, 16'(8'h11 * (i + 1)), "load");
    sweep(0, 1'b1, 1, 16'h77, "clr4");
    issue(0, OP_WRITE, 2, 2, 3, 16'h5A, "pre2");
    issue(0, OP_WRITE, 3, 2, 3, 16'hC3, "pre3");
    drv(0, OP_CLEAR, 1'b1, 0, 2, 3, 16'h0);
    @(posedge clk); #1;
    drv(0, OP_NOP, 1'b0, 0, 2, 3, 16'h0);
    @(posedge clk); #1;
    push("mid_busy", 0, K_BUSY, 16'h1);
    push("mid_keep", 0, K_B, 16'hC3);
    drain();
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) m[s][i] = 16'h0;
    push("mrst_outa", 0, K_A, 16'h0);
    push("mrst_outb", 0, K_B, 16'h0);
    push("mrst_oix", 0, K_IX, 16'h0);
    push("mrst_busy", 0, K_BUSY, 16'h0);
    push("mrst_rdy", 0, K_RDY, 16'h1);
    drain();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    push("post_busy", 0, K_BUSY, 16'h0);
    push("post_rdy", 0, K_RDY, 16'h1);
    drain();
    issue(0, OP_WRITE, 0, 0, 3, 16'h12, "post_wr");
    issue(1, OP_WRITE, 0, 0, 7, 16'h1234, "b_wr0");
    issue(1, OP_WRITE, 7, 0, 7, 16'hBEEF, "b_wrix");
    issue(1, OP_SWAP, 0, 0, 7, 16'h0, "b_swap");
    issue(1, OP_WRITE, 7, 0, 7, 16'hFFFF, "b_wrff");
    issue(1, OP_INC_IX, 0, 0, 7, 16'h0, "b_inc_wrap");
    issue(1, OP_DEC_IX, 0, 0, 7, 16'h0, "b_dec_wrap");
    for (int i = 1; i < 7; i++) issue(1, OP_WRITE, i, i, 7, 16'(16'h1111 * i), "b_load");
    sweep(1, 1'b0, 0, 16'h0, "b_clr8");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
